// File: rtl/mem_responder_direct.sv
// In-order memory responder: queues read requests and answers each after a fixed latency.
// Optional MEM_WRITE_EN adds write requests backed by a storage array with per-word written bits.
module mem_responder_direct #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32,
   parameter int LATENCY    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
`ifdef MEM_WRITE_EN
   input  logic                  req_write,
   input  logic [DATA_WIDTH-1:0] req_wdata,
`endif
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [ADDR_WIDTH-1:0] resp_addr,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  busy
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int HW = DATA_WIDTH / 2;
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
   localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t                state_reg, state_next;
   logic [3:0]            cnt_reg, cnt_next;
   logic [PW:0]           wr_ptr_reg, rd_ptr_reg;
   logic [PW-1:0]         wr_idx, rd_idx;
   logic                  empty, full, push, pop, load_resp;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [ADDR_WIDTH-1:0] resp_addr_reg;
   logic [DATA_WIDTH-1:0] resp_data_reg, resp_data_next;
   logic [ADDR_WIDTH-1:0] entry_addr [FIFO_DEPTH];

   function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
      logic [HW-1:0] h;
      h = HW'(a);
      return {h, h};
   endfunction

   assign wr_idx    = wr_ptr_reg[PW-1:0];
   assign rd_idx    = rd_ptr_reg[PW-1:0];
   assign empty     = (wr_ptr_reg == rd_ptr_reg);
   assign full      = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) && (wr_idx == rd_idx);
   assign req_ready = !full;
   // A full queue refuses the push even when the FSM pops in the same cycle.
   assign push      = req_valid && !full;

`ifdef MEM_WRITE_EN
   logic                  entry_write [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] entry_wdata [FIFO_DEPTH];
   logic                  write_reg;
   logic [DATA_WIDTH-1:0] wdata_reg, mem_rd_reg;
   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic [2**ADDR_WIDTH-1:0] written_reg;
`endif

   generate
      for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
         logic [ADDR_WIDTH-1:0] slot_addr_reg;
         always_ff @(posedge clk) begin
            if (push && wr_idx == PW'(gi)) slot_addr_reg <= req_addr;
         end
         assign entry_addr[gi] = slot_addr_reg;
`ifdef MEM_WRITE_EN
         logic                  slot_write_reg;
         logic [DATA_WIDTH-1:0] slot_wdata_reg;
         always_ff @(posedge clk) begin
            if (push && wr_idx == PW'(gi)) begin
               slot_write_reg <= req_write;
               slot_wdata_reg <= req_wdata;
            end
         end
         assign entry_write[gi] = slot_write_reg;
         assign entry_wdata[gi] = slot_wdata_reg;
`endif
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      pop        = 1'b0;
      load_resp  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               state_next = ST_WAIT;
               cnt_next   = CNT_LOAD;
            end
         end
         ST_WAIT: begin
            // Leave as the counter reaches zero; LATENCY=1 loads zero and still waits one cycle.
            if (cnt_reg <= 4'd1) begin
               state_next = ST_RESP;
               load_resp  = 1'b1;
            end
            if (cnt_reg != 4'd0) cnt_next = cnt_reg - 4'd1;
         end
         ST_RESP: begin
            if (resp_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

`ifdef MEM_WRITE_EN
   assign resp_data_next = write_reg ? wdata_reg :
                           (written_reg[addr_reg] ? mem_rd_reg : pattern(addr_reg));

   // Writes commit on WAIT->RESP; a later read pops only after that, so it sees the new word.
   always_ff @(posedge clk) begin
      if (load_resp && write_reg) mem[addr_reg] <= wdata_reg;
      if (pop) mem_rd_reg <= mem[entry_addr[rd_idx]];
   end
`else
   assign resp_data_next = pattern(addr_reg);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         addr_reg      <= '0;
         resp_addr_reg <= '0;
         resp_data_reg <= '0;
`ifdef MEM_WRITE_EN
         write_reg     <= 1'b0;
         wdata_reg     <= '0;
         written_reg   <= '0;
`endif
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            addr_reg   <= entry_addr[rd_idx];
`ifdef MEM_WRITE_EN
            write_reg  <= entry_write[rd_idx];
            wdata_reg  <= entry_wdata[rd_idx];
`endif
         end
         if (load_resp) begin
            resp_addr_reg <= addr_reg;
            resp_data_reg <= resp_data_next;
`ifdef MEM_WRITE_EN
            if (write_reg) written_reg[addr_reg] <= 1'b1;
`endif
         end
      end
   end

   assign resp_valid = (state_reg == ST_RESP);
   assign resp_addr  = resp_addr_reg;
   assign resp_data  = resp_data_reg;
   assign busy       = !empty || (state_reg != ST_IDLE);
endmodule

// File: tb/tb_mem_responder_direct.sv
// Directed bench for mem_responder_direct: table of per-cycle vectors plus multi-cycle sequences.
// Write-path checks are compiled in when MEM_WRITE_EN is defined.
module tb_mem_responder_direct;
   localparam int AW  = 11;
   localparam int DW  = 32;
   localparam int LAT = 4;
   localparam int NV  = 17;

   typedef struct {
      logic          req_valid;
      logic [AW-1:0] req_addr;
      logic          resp_ready;
      logic          exp_req_ready;
      logic          exp_resp_valid;
      logic [AW-1:0] exp_resp_addr;
      logic [DW-1:0] exp_resp_data;
      logic          exp_busy;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_addr = '0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [AW-1:0] resp_addr;
   logic [DW-1:0] resp_data;
   logic          busy;
`ifdef MEM_WRITE_EN
   logic          req_write = 1'b0;
   logic [DW-1:0] req_wdata = '0;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [AW-1:0] got_addr [$];
   logic [DW-1:0] got_data [$];
   int            got_cyc  [$];
   vec_t          vecs [NV];

   always #5 clk = ~clk;

   mem_responder_direct dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
`ifdef MEM_WRITE_EN
      .req_write  (req_write),
      .req_wdata  (req_wdata),
`endif
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_addr  (resp_addr),
      .resp_data  (resp_data),
      .busy       (busy)
   );

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Records a response transfer (it completes at the coming edge), then advances one cycle.
   task automatic step();
      if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
         got_addr.push_back(resp_addr);
         got_data.push_back(resp_data);
         got_cyc.push_back(cyc);
         $display("resp #%0d addr=%03h data=%08h cycle=%0d", got_addr.size() - 1, resp_addr, resp_data, cyc);
      end
      tick();
   endtask

   function automatic vec_t mk(logic v, logic [AW-1:0] a, logic rr, logic er, logic ev,
                               logic [AW-1:0] ea, logic [DW-1:0] ed, logic eb);
      vec_t t;
      t.req_valid      = v;
      t.req_addr       = a;
      t.resp_ready     = rr;
      t.exp_req_ready  = er;
      t.exp_resp_valid = ev;
      t.exp_resp_addr  = ea;
      t.exp_resp_data  = ed;
      t.exp_busy       = eb;
      return t;
   endfunction

   task automatic single_req(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
      int n0;
      int t0;
      bit acc;
      n0 = got_addr.size();
      resp_ready = 1'b1;
      req_valid  = 1'b1;
      req_addr   = a;
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
         acc = req_ready;
         step();
      end
      req_valid = 1'b0;
      t0 = cyc;
      check({name, "_accept"}, 64'(acc), 64'(1));
      for (int i = 0; i < 40 && got_addr.size() == n0; i++) step();
      check({name, "_count"}, 64'(got_addr.size() - n0), 64'(1));
      if (got_addr.size() > n0) begin
         check({name, "_addr"}, 64'(got_addr[n0]), 64'(a));
         check({name, "_data"}, 64'(got_data[n0]), 64'(exp));
         check({name, "_latency"}, 64'(got_cyc[n0] - t0), 64'(LAT));
      end
   endtask

   initial begin
      logic [AW-1:0] t3_addr [4];
      logic [DW-1:0] t3_data [4];
      logic [AW-1:0] t4_addr [6];
      int n0;
      int idx;
      bit acc;

      t3_addr = '{11'h200, 11'h034, 11'h512, 11'h100};
      t3_data = '{32'h0200_0200, 32'h0034_0034, 32'h0512_0512, 32'h0100_0100};
      t4_addr = '{11'h010, 11'h020, 11'h030, 11'h040, 11'h050, 11'h060};

      // Single read of 0x034, then two back-to-back reads where the second push meets the first pop.
      vecs[0]  = mk(1'b1, 11'h034, 1'b1, 1'b1, 1'b0, 11'h000, 32'h0, 1'b1);
      vecs[1]  = mk(1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 11'h000, 32'h0, 1'b1);
      vecs[2]  = mk(1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 11'h000, 32'h0, 1'b1);
      vecs[3]  = mk(1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 11'h000, 32'h0, 1'b1);
      vecs[4]  = mk(1'b0, 11'h000, 1'b1, 1'b1, 1'b1, 11'h034, 32'h0034_0034, 1'b1);
      vecs[5]  = mk(1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 11'h000, 32'h0, 1'b0);
      vecs[6]  = mk(1'b1, 11'h0AA, 1'b1, 1'b1, 1'b0, 11'h000, 32'h0, 1'b1);
      vecs[7]  = mk(1'b1, 11'h155, 1'b1, 1'b1, 1'b0, 11'h000, 32'h0, 1'b1);
      vecs[8]  = mk(1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 11'h000, 32'h0, 1'b1);
      vecs[9]  = mk(1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 11'h000, 32'h0, 1'b1);
      vecs[10] = mk(1'b0, 11'h000, 1'b1, 1'b1, 1'b1, 11'h0AA, 32'h00AA_00AA, 1'b1);
      vecs[11] = mk(1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 11'h000, 32'h0, 1'b1);
      vecs[12] = mk(1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 11'h000, 32'h0, 1'b1);
      vecs[13] = mk(1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 11'h000, 32'h0, 1'b1);
      vecs[14] = mk(1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 11'h000, 32'h0, 1'b1);
      vecs[15] = mk(1'b0, 11'h000, 1'b1, 1'b1, 1'b1, 11'h155, 32'h0155_0155, 1'b1);
      vecs[16] = mk(1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 11'h000, 32'h0, 1'b0);

      // Reset values
      repeat (3) tick();
      check("rst_req_ready", 64'(req_ready), 64'(1));
      check("rst_resp_valid", 64'(resp_valid), 64'(0));
      check("rst_resp_addr", 64'(resp_addr), 64'(0));
      check("rst_resp_data", 64'(resp_data), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      rst = 1'b1;
      tick();

      // Table vectors: one row per cycle
      for (int i = 0; i < NV; i++) begin
         req_valid  = vecs[i].req_valid;
         req_addr   = vecs[i].req_addr;
         resp_ready = vecs[i].resp_ready;
         tick();
         check($sformatf("vec%0d_req_ready", i), 64'(req_ready), 64'(vecs[i].exp_req_ready));
         check($sformatf("vec%0d_resp_valid", i), 64'(resp_valid), 64'(vecs[i].exp_resp_valid));
         check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
         if (vecs[i].exp_resp_valid) begin
            check($sformatf("vec%0d_resp_addr", i), 64'(resp_addr), 64'(vecs[i].exp_resp_addr));
            check($sformatf("vec%0d_resp_data", i), 64'(resp_data), 64'(vecs[i].exp_resp_data));
         end
      end
      req_valid = 1'b0;

      // Four back-to-back reads: order, data and LATENCY+1 spacing
      n0 = got_addr.size();
      resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1;
         req_addr  = t3_addr[i];
         check($sformatf("t3_req_ready%0d", i), 64'(req_ready), 64'(1));
         step();
      end
      req_valid = 1'b0;
      for (int i = 0; i < 60 && got_addr.size() < n0 + 4; i++) step();
      check("t3_count", 64'(got_addr.size() - n0), 64'(4));
      for (int i = 0; i < 4 && n0 + i < got_addr.size(); i++) begin
         check($sformatf("t3_addr%0d", i), 64'(got_addr[n0 + i]), 64'(t3_addr[i]));
         check($sformatf("t3_data%0d", i), 64'(got_data[n0 + i]), 64'(t3_data[i]));
         if (i > 0) check($sformatf("t3_spacing%0d", i), 64'(got_cyc[n0 + i] - got_cyc[n0 + i - 1]), 64'(LAT + 1));
      end

      // Backpressure: five accepted (four queued, one in flight), response held stable
      n0 = got_addr.size();
      resp_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 12; c++) begin
         req_valid = (idx < 6);
         req_addr  = t4_addr[idx < 6 ? idx : 5];
         acc = req_valid && req_ready;
         step();
         if (acc) idx++;
      end
      req_valid = 1'b0;
      check("t4_accepted", 64'(idx), 64'(5));
      check("t4_req_ready_full", 64'(req_ready), 64'(0));
      for (int c = 0; c < 3; c++) begin
         check($sformatf("t4_stall_valid%0d", c), 64'(resp_valid), 64'(1));
         check($sformatf("t4_stall_addr%0d", c), 64'(resp_addr), 64'(11'h010));
         check($sformatf("t4_stall_data%0d", c), 64'(resp_data), 64'(32'h0010_0010));
         step();
      end
      resp_ready = 1'b1;
      for (int i = 0; i < 80 && got_addr.size() < n0 + 5; i++) step();
      check("t4_count", 64'(got_addr.size() - n0), 64'(5));
      for (int i = 0; i < 5 && n0 + i < got_addr.size(); i++) begin
         check($sformatf("t4_addr%0d", i), 64'(got_addr[n0 + i]), 64'(t4_addr[i]));
         check($sformatf("t4_data%0d", i), 64'(got_data[n0 + i]), 64'({5'b0, t4_addr[i], 5'b0, t4_addr[i]}));
      end
      step();
      check("t4_idle_busy", 64'(busy), 64'(0));

      // Asynchronous reset in the middle of WAIT discards the request
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_addr   = 11'h03A;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      #3;
      rst = 1'b0;
      #1;
      check("t1_resp_valid", 64'(resp_valid), 64'(0));
      check("t1_req_ready", 64'(req_ready), 64'(1));
      check("t1_busy", 64'(busy), 64'(0));
      #2;
      rst = 1'b1;
      tick();
      n0 = got_addr.size();
      resp_ready = 1'b1;
      for (int i = 0; i < 10; i++) step();
      check("t1_no_stale", 64'(got_addr.size() - n0), 64'(0));
      check("t1_busy_after", 64'(busy), 64'(0));

      // Address extremes
      single_req(11'h7FF, 32'h07FF_07FF, "max_addr");
      single_req(11'h000, 32'h0000_0000, "zero_addr");

`ifdef MEM_WRITE_EN
      req_write = 1'b1;
      req_wdata = 32'hDEAD_BEEF;
      single_req(11'h034, 32'hDEAD_BEEF, "t6_write");
      req_write = 1'b0;
      req_wdata = '0;
      single_req(11'h034, 32'hDEAD_BEEF, "t6_read_back");
      single_req(11'h035, 32'h0035_0035, "t6_read_unwritten");
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      single_req(11'h034, 32'h0034_0034, "t6_after_reset");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
